// File: rtl/argmax_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : argmax_stream_ctrl_if
// Brief    : Job control, beat input and result handshake bundle for argmax.
// Revision : 1.0
// ============================================================================
interface argmax_stream_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_DATA   = 16,
   parameter int MAX_BEATS  = 64
);
   localparam int IDX_W = $clog2(NUM_DATA * MAX_BEATS);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   logic                           start;
   logic [CNT_W-1:0]               cfg_num_beats;
   logic                           busy;
   logic                           in_valid;
   logic                           in_ready;
   logic [DATA_WIDTH*NUM_DATA-1:0] in_data;
   logic                           out_valid;
   logic                           out_ready;
   logic [DATA_WIDTH-1:0]          out_max;
   logic [IDX_W-1:0]               out_idx;
   logic                           out_err;

   modport master (
      output start, cfg_num_beats, in_valid, in_data, out_ready,
      input  busy, in_ready, out_valid, out_max, out_idx, out_err
   );

   modport slave (
      input  start, cfg_num_beats, in_valid, in_data, out_ready,
      output busy, in_ready, out_valid, out_max, out_idx, out_err
   );
endinterface
`default_nettype wire

// File: rtl/argmax_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : argmax_stream_ctrl
// Brief    : Multi-beat streaming argmax: per-beat max tree plus running max.
// Revision : 1.0
// ============================================================================
module argmax_stream_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_DATA   = 16,
   parameter int MAX_BEATS  = 64
) (
   input logic           clk,
   input logic           reset,
   argmax_stream_ctrl_if.slave bus
);
   localparam int IDX_W  = $clog2(NUM_DATA * MAX_BEATS);
   localparam int CNT_W  = $clog2(MAX_BEATS + 1);
   localparam int LANE_W = (NUM_DATA > 1) ? $clog2(NUM_DATA) : 1;
   localparam int NODES  = 2 * NUM_DATA - 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      num_beats_q;
   logic [CNT_W-1:0]      beat_cnt_q;
   logic                  s1_valid_q;
   logic                  s1_first_q;
   logic                  s1_last_q;
   logic [DATA_WIDTH-1:0] s1_max_q;
   logic [IDX_W-1:0]      s1_idx_q;
   logic                  s2_done_q;
   logic [DATA_WIDTH-1:0] run_max_q;
   logic [IDX_W-1:0]      run_idx_q;
   logic                  err_q;

   logic                  w_cfg_bad;
   logic                  w_accept;
   logic                  w_last;
   logic [IDX_W-1:0]      w_gidx;
   logic [DATA_WIDTH-1:0] w_tv [NODES];
   logic [LANE_W-1:0]     w_tl [NODES];

   assign w_cfg_bad = (bus.cfg_num_beats == '0) || (bus.cfg_num_beats > CNT_W'(MAX_BEATS));
   assign w_accept  = (state_q == S_RUN) && bus.in_valid;
   assign w_last    = (beat_cnt_q == num_beats_q - CNT_W'(1));

   // Heap-ordered tree: left children always cover lower lanes, so a strict
   // right-over-left compare keeps the lowest lane on ties.
   always_comb begin
      for (int k = 0; k < NUM_DATA; k++) begin
         w_tv[NUM_DATA-1+k] = bus.in_data[DATA_WIDTH*k +: DATA_WIDTH];
         w_tl[NUM_DATA-1+k] = LANE_W'(k);
      end
      for (int n = NUM_DATA - 2; n >= 0; n--) begin
         if (w_tv[2*n+2] > w_tv[2*n+1]) begin
            w_tv[n] = w_tv[2*n+2];
            w_tl[n] = w_tl[2*n+2];
         end else begin
            w_tv[n] = w_tv[2*n+1];
            w_tl[n] = w_tl[2*n+1];
         end
      end
   end

   assign w_gidx = IDX_W'(beat_cnt_q) * IDX_W'(NUM_DATA) + IDX_W'(w_tl[0]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d       = state_q;
      bus.busy      = (state_q != S_IDLE);
      bus.in_ready  = (state_q == S_RUN);
      bus.out_valid = (state_q == S_DONE);
      bus.out_err   = (state_q == S_DONE) && err_q;
      bus.out_max   = run_max_q;
      bus.out_idx   = run_idx_q;
      case (state_q)
         S_IDLE:  if (bus.start)             state_d = w_cfg_bad ? S_DONE : S_RUN;
         S_RUN:   if (w_accept && w_last)    state_d = S_DRAIN;
         S_DRAIN: if (s2_done_q)             state_d = S_DONE;
         S_DONE:  if (bus.out_ready)         state_d = S_IDLE;
         default:                            state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_beats_q <= '0;
         beat_cnt_q  <= '0;
         s1_valid_q  <= 1'b0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_max_q    <= '0;
         s1_idx_q    <= '0;
         s2_done_q   <= 1'b0;
         run_max_q   <= '0;
         run_idx_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         s1_valid_q <= w_accept;
         s2_done_q  <= s1_valid_q && s1_last_q;

         if ((state_q == S_IDLE) && bus.start) begin
            num_beats_q <= bus.cfg_num_beats;
            beat_cnt_q  <= '0;
            err_q       <= w_cfg_bad;
            if (w_cfg_bad) begin
               run_max_q <= '0;
               run_idx_q <= '0;
            end
         end

         if (w_accept) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            s1_max_q   <= w_tv[0];
            s1_idx_q   <= w_gidx;
            s1_first_q <= (beat_cnt_q == '0);
            s1_last_q  <= w_last;
         end

         // Strict compare: an earlier beat keeps the lead on equal values.
         if (s1_valid_q && (s1_first_q || (s1_max_q > run_max_q))) begin
            run_max_q <= s1_max_q;
            run_idx_q <= s1_idx_q;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_argmax_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_stream_ctrl
// Brief    : Scoreboard bench for argmax_stream_ctrl with a reference model.
// Revision : 1.0
// ============================================================================
module tb_argmax_stream_ctrl;
   localparam int DW    = 8;
   localparam int ND    = 16;
   localparam int MB    = 64;
   localparam int IDX_W = $clog2(ND * MB);
   localparam int CNT_W = $clog2(MB + 1);

   typedef struct packed {
      logic [DW-1:0]    mx;
      logic [IDX_W-1:0] idx;
      logic             err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   argmax_stream_ctrl_if #(.DATA_WIDTH(DW), .NUM_DATA(ND), .MAX_BEATS(MB)) bus ();

   argmax_stream_ctrl #(.DATA_WIDTH(DW), .NUM_DATA(ND), .MAX_BEATS(MB)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   exp_t             exp_q[$];
   exp_t             mon_e;
   int               checks = 0;
   int               errors = 0;
   logic [DW*ND-1:0] beat_mem [MB];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Argmax over the flattened element list; first occurrence wins.
   function automatic exp_t ref_model(input int nb);
      exp_t r;
      logic [DW-1:0] v;
      r = '0;
      if (nb < 1 || nb > MB) begin
         r.err = 1'b1;
         return r;
      end
      for (int b = 0; b < nb; b++)
         for (int k = 0; k < ND; k++) begin
            v = beat_mem[b][DW*k +: DW];
            if ((b == 0 && k == 0) || v > r.mx) begin
               r.mx  = v;
               r.idx = IDX_W'(b * ND + k);
            end
         end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got max=0x%0h idx=%0d, expected no result",
                     bus.out_max, bus.out_idx);
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_max", 32'(bus.out_max), 32'(mon_e.mx));
            chk("out_idx", 32'(bus.out_idx), 32'(mon_e.idx));
            chk("out_err", 32'(bus.out_err), 32'(mon_e.err));
         end
      end
   end

   // hold < 0: out_ready high in advance; otherwise held low for hold DONE cycles.
   task automatic run_job(input int nb, input int gap, input int hold, input bit poke);
      int g;
      logic [DW-1:0]    mx;
      logic [IDX_W-1:0] ix;
      exp_q.push_back(ref_model(nb));
      bus.out_ready     = (hold < 0);
      bus.start         = 1'b1;
      bus.cfg_num_beats = CNT_W'(nb);
      tick();
      bus.start = 1'b0;
      chk("busy_run", 32'(bus.busy), 1);
      for (int b = 0; b < nb; b++) begin
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         for (int i = 0; i < g; i++) begin
            bus.in_valid = 1'b0;
            bus.in_data  = {4{$urandom}};
            if (poke && i == 0) begin
               bus.start         = 1'b1;
               bus.cfg_num_beats = CNT_W'(1);
            end
            tick();
            bus.start = 1'b0;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = beat_mem[b];
         chk("in_ready_run", 32'(bus.in_ready), 1);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_data  = {4{$urandom}};
      chk("in_ready_after_last", 32'(bus.in_ready), 0);
      chk("out_valid_lat0", 32'(bus.out_valid), 0);
      tick();
      chk("out_valid_lat1", 32'(bus.out_valid), 0);
      tick();
      chk("out_valid_lat2", 32'(bus.out_valid), 1);
      if (hold >= 0) begin
         mx = bus.out_max;
         ix = bus.out_idx;
         for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
               bus.start         = 1'b1;
               bus.cfg_num_beats = CNT_W'(2);
            end
            tick();
            bus.start = 1'b0;
            chk("hold_out_valid", 32'(bus.out_valid), 1);
            chk("hold_busy", 32'(bus.busy), 1);
            chk("hold_max_stable", 32'(bus.out_max), 32'(mx));
            chk("hold_idx_stable", 32'(bus.out_idx), 32'(ix));
         end
         bus.out_ready = 1'b1;
      end
      tick();
      chk("out_valid_after_hs", 32'(bus.out_valid), 0);
      chk("busy_after_hs", 32'(bus.busy), 0);
      bus.out_ready = 1'b0;
   endtask

   task automatic err_job(input int cfg);
      exp_q.push_back(ref_model(cfg));
      bus.out_ready     = 1'b1;
      bus.start         = 1'b1;
      bus.cfg_num_beats = CNT_W'(cfg);
      bus.in_valid      = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("err_out_valid", 32'(bus.out_valid), 1);
      chk("err_in_ready", 32'(bus.in_ready), 0);
      chk("err_busy", 32'(bus.busy), 1);
      tick();
      bus.in_valid = 1'b0;
      chk("err_out_valid_after", 32'(bus.out_valid), 0);
      chk("err_in_ready_after", 32'(bus.in_ready), 0);
      bus.out_ready = 1'b0;
   endtask

   task automatic fill_rand(input int nb, input int hi);
      for (int b = 0; b < nb; b++)
         for (int k = 0; k < ND; k++)
            beat_mem[b][DW*k +: DW] = DW'($urandom_range(0, hi));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n             = 1'b0;
      bus.start         = 1'b0;
      bus.cfg_num_beats = '0;
      bus.in_valid      = 1'b0;
      bus.in_data       = '0;
      bus.out_ready     = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_err", 32'(bus.out_err), 0);
      chk("rst_out_max", 32'(bus.out_max), 0);
      chk("rst_out_idx", 32'(bus.out_idx), 0);
      rst_n = 1'b1;
      tick();

      // Single beat, lane 5 dominant.
      for (int k = 0; k < ND; k++) beat_mem[0][DW*k +: DW] = 8'h10;
      beat_mem[0][DW*5 +: DW] = 8'hF0;
      run_job(1, 0, -1, 1'b0);

      // Tie inside one beat.
      fill_rand(1, 8'hA9);
      beat_mem[0][DW*3 +: DW] = 8'hAA;
      beat_mem[0][DW*9 +: DW] = 8'hAA;
      run_job(1, 0, 2, 1'b0);

      // Tie across beats.
      fill_rand(2, 8'h7F);
      beat_mem[0][DW*7 +: DW] = 8'h80;
      beat_mem[1][DW*2 +: DW] = 8'h80;
      run_job(2, 0, -1, 1'b0);

      // Four beats with gaps, winner in the very last element; backpressure in DONE.
      fill_rand(4, 8'hFE);
      beat_mem[1][DW*4 +: DW] = 8'hFE;
      beat_mem[3][DW*15 +: DW] = 8'hFF;
      run_job(4, 2, 5, 1'b1);

      // Immediate follow-up job.
      fill_rand(1, 8'hFF);
      run_job(1, 0, -1, 1'b0);

      err_job(0);
      err_job(65);

      for (int b = 0; b < 2; b++) beat_mem[b] = '0;
      run_job(2, 1, 0, 1'b0);

      // Reset in the middle of a job.
      for (int b = 0; b < 4; b++)
         for (int k = 0; k < ND; k++) beat_mem[b][DW*k +: DW] = 8'hFF;
      bus.start         = 1'b1;
      bus.cfg_num_beats = CNT_W'(4);
      tick();
      bus.start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = beat_mem[b];
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(bus.busy), 0);
      chk("arst_in_ready", 32'(bus.in_ready), 0);
      chk("arst_out_valid", 32'(bus.out_valid), 0);
      chk("arst_out_err", 32'(bus.out_err), 0);
      chk("arst_out_max", 32'(bus.out_max), 0);
      chk("arst_out_idx", 32'(bus.out_idx), 0);
      tick();
      rst_n = 1'b1;
      tick();
      fill_rand(1, 8'h3F);
      run_job(1, 0, -1, 1'b0);

      // Randomized back-to-back jobs with heavy ties.
      for (int j = 0; j < 25; j++) begin
         fill_rand(8, (j % 2 == 0) ? 31 : 255);
         run_job(int'($urandom_range(1, 8)), -1,
                 (j % 3 == 0) ? -1 : int'($urandom_range(0, 2)), j[0]);
      end

      // Longest legal job.
      fill_rand(MB, 8'hFF);
      run_job(MB, 0, -1, 1'b0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
